noc_traffic_pe: RTL and testbench

Synthesizable per-node traffic generator and checker for the OpenNoc mesh; it replaces behavioural PE stimulus with a block that can sit on silicon or in emulation. Each instance injects a configurable number of packets in a selectable spatial pattern at a fixed injection interval, and timestamps each packet. On the ejection side it counts arrivals, checks the destination and accumulates latency statistics. One instance attaches to each router's PE port inside a top level that fans out `X*Y` copies.

---
 rtl/noc_pkg.sv | 34 +++
 rtl/noc_dest_gen.sv | 69 ++++++
 rtl/noc_traffic_pe.sv | 239 +++++++++++++++++++++++
 tb/tb_noc_traffic_pe.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared definitions for the NoC traffic generator/checker: pattern codes,
// payload field offsets and the injection FSM state type.
package noc_pkg;

    localparam int unsigned PAT_RANDOM    = 0;
    localparam int unsigned PAT_TRANSPOSE = 1;
    localparam int unsigned PAT_BITCOMP   = 2;
    localparam int unsigned PAT_HOTSPOT   = 3;

    // Offsets are relative to the first payload bit (just above dest y).
    localparam int unsigned SEQ_LSB  = 0;
    localparam int unsigned SEQ_W    = 16;
    localparam int unsigned TS_LSB   = 16;
    localparam int unsigned TS_W     = 32;
    localparam int unsigned SRCX_LSB = 48;
    localparam int unsigned SRCY_LSB = 56;
    localparam int unsigned SRC_W    = 8;

    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GEN,
        ST_HOLD,
        ST_GAP,
        ST_DONE
    } pe_state_e;

    // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

endpackage

// File: rtl/noc_dest_gen.sv
// Destination generator: LFSR-driven random draw or fixed spatial pattern,
// with self-avoidance (a destination equal to this node moves to x+1 mod X).
module noc_dest_gen
    import noc_pkg::*;
#(
    parameter int unsigned X       = 10,
    parameter int unsigned Y       = 10,
    parameter int unsigned x_size  = $clog2(X),
    parameter int unsigned y_size  = $clog2(Y),
    parameter int unsigned MY_X    = 0,
    parameter int unsigned MY_Y    = 0,
    parameter int unsigned PATTERN = 0,
    parameter int unsigned HOT_X   = 0,
    parameter int unsigned HOT_Y   = 0,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              adv_i,
    output logic [x_size-1:0] dest_x_o,
    output logic [y_size-1:0] dest_y_o
);

    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? LFSR_DEFAULT_SEED : SEED;

    logic [15:0]       lfsr_q, lfsr_d;
    logic [x_size-1:0] raw_x;
    logic [y_size-1:0] raw_y;
    logic              is_self;

    // The current value is the draw; the register steps once it is consumed.
    always_comb begin
        lfsr_d = lfsr_q;
        if (adv_i && (PATTERN == PAT_RANDOM)) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= SEED_EFF;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    always_comb begin
        raw_x = '0;
        raw_y = '0;
        if (PATTERN == PAT_RANDOM) begin
            raw_x = x_size'(32'(lfsr_q[7:0]) % X);
            raw_y = y_size'(32'(lfsr_q[15:8]) % Y);
        end else if (PATTERN == PAT_TRANSPOSE) begin
            raw_x = x_size'(MY_Y);
            raw_y = y_size'(MY_X);
        end else if (PATTERN == PAT_BITCOMP) begin
            raw_x = x_size'(X - 1 - MY_X);
            raw_y = y_size'(Y - 1 - MY_Y);
        end else begin
            raw_x = x_size'(HOT_X);
            raw_y = y_size'(HOT_Y);
        end
    end

    assign is_self  = (raw_x == x_size'(MY_X)) && (raw_y == y_size'(MY_Y));
    assign dest_x_o = is_self ? x_size'((MY_X + 1) % X) : raw_x;
    assign dest_y_o = raw_y;

endmodule

// File: rtl/noc_traffic_pe.sv
// Per-node NoC traffic generator (inject FSM) and ejection checker.
// Define TRAFFIC_LATENCY_STATS_EN to timestamp flits and accumulate latency.
module noc_traffic_pe
    import noc_pkg::*;
#(
    parameter int unsigned X           = 10,
    parameter int unsigned Y           = 10,
    parameter int unsigned x_size      = $clog2(X),
    parameter int unsigned y_size      = $clog2(Y),
    parameter int unsigned data_width  = 256,
    parameter int unsigned MY_X        = 0,
    parameter int unsigned MY_Y        = 0,
    parameter int unsigned NUM_PACKETS = 1000,
    parameter int unsigned RATE        = 1,
    parameter int unsigned PATTERN     = 0,
    parameter int unsigned HOT_X       = 0,
    parameter int unsigned HOT_Y       = 0,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 start,
    input  logic                                 clr_stats,
    output logic                                 o_valid,
    output logic [x_size+y_size+data_width-1:0]  o_data,
    input  logic                                 i_ready,
    input  logic                                 i_valid,
    input  logic [x_size+y_size+data_width-1:0]  i_data,
    output logic                                 done,
    output logic [31:0]                          send_count,
    output logic [31:0]                          recv_count,
    output logic [15:0]                          err_count,
    output logic [47:0]                          lat_sum,
    output logic [31:0]                          lat_max
);

    localparam int unsigned T  = x_size + y_size + data_width;
    localparam int unsigned PL = x_size + y_size;

    pe_state_e         state_q, state_d;
    logic [31:0]       cyc_q;
    logic [31:0]       send_q, send_d;
    logic [15:0]       seq_q, seq_d;
    logic [31:0]       gap_q, gap_d;
    logic              done_q, done_d;
    logic              valid_q, valid_d;
    logic [T-1:0]      data_q, data_d;
    logic [T-1:0]      flit;
    logic              draw;
    logic [x_size-1:0] dest_x;
    logic [y_size-1:0] dest_y;
    logic [31:0]       recv_q;
    logic [15:0]       err_q;
    logic              rx_bad;

    noc_dest_gen #(
        .X       (X),
        .Y       (Y),
        .x_size  (x_size),
        .y_size  (y_size),
        .MY_X    (MY_X),
        .MY_Y    (MY_Y),
        .PATTERN (PATTERN),
        .HOT_X   (HOT_X),
        .HOT_Y   (HOT_Y),
        .SEED    (SEED)
    ) u_dest (
        .clk_i    (clk),
        .rst_ni   (rstn),
        .adv_i    (draw),
        .dest_x_o (dest_x),
        .dest_y_o (dest_y)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_q + 32'd1;
        end
    end

    always_comb begin
        flit = '0;
        flit[x_size-1:0]           = dest_x;
        flit[x_size +: y_size]     = dest_y;
        flit[PL+SEQ_LSB +: SEQ_W]  = seq_q;
`ifdef TRAFFIC_LATENCY_STATS_EN
        flit[PL+TS_LSB +: TS_W]    = cyc_q;
`endif
        flit[PL+SRCX_LSB +: SRC_W] = SRC_W'(MY_X);
        flit[PL+SRCY_LSB +: SRC_W] = SRC_W'(MY_Y);
    end

    always_comb begin
        state_d = state_q;
        send_d  = send_q;
        seq_d   = seq_q;
        gap_d   = gap_q;
        done_d  = done_q;
        valid_d = valid_q;
        data_d  = data_q;
        draw    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    send_d  = '0;
                    seq_d   = '0;
                    done_d  = 1'b0;
                    state_d = ST_GEN;
                end
            end
            ST_GEN: begin
                valid_d = 1'b1;
                data_d  = flit;
                draw    = 1'b1;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                // A presented flit always completes its handshake; start is
                // only honoured once it has been accepted.
                if (i_ready) begin
                    valid_d = 1'b0;
                    send_d  = send_q + 32'd1;
                    seq_d   = seq_q + 16'd1;
                    if (send_q + 32'd1 == 32'(NUM_PACKETS)) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else if (!start) begin
                        state_d = ST_IDLE;
                    end else if (RATE == 1) begin
                        state_d = ST_GEN;
                    end else begin
                        gap_d   = 32'(RATE - 1);
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end else if (gap_q <= 32'd1) begin
                    state_d = ST_GEN;
                end else begin
                    gap_d = gap_q - 32'd1;
                end
            end
            ST_DONE: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            send_q  <= '0;
            seq_q   <= '0;
            gap_q   <= '0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            send_q  <= send_d;
            seq_q   <= seq_d;
            gap_q   <= gap_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign o_valid    = valid_q;
    assign o_data     = data_q;
    assign done       = done_q;
    assign send_count = send_q;

    assign rx_bad = (i_data[x_size-1:0] != x_size'(MY_X)) ||
                    (i_data[PL-1:x_size] != y_size'(MY_Y));

    // A clear coinciding with an arrival wins; that packet is not counted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            recv_q <= '0;
            err_q  <= '0;
        end else if (clr_stats) begin
            recv_q <= '0;
            err_q  <= '0;
        end else if (i_valid) begin
            recv_q <= recv_q + 32'd1;
            if (rx_bad && (err_q != 16'hFFFF)) begin
                err_q <= err_q + 16'd1;
            end
        end
    end

    assign recv_count = recv_q;
    assign err_count  = err_q;

`ifdef TRAFFIC_LATENCY_STATS_EN
    logic [47:0] lat_sum_q;
    logic [31:0] lat_max_q;
    logic [31:0] rx_lat;
    logic        rx_unused;

    // Modulo-2^32 difference keeps latency correct across a cyc wrap.
    assign rx_lat = cyc_q - i_data[PL+TS_LSB +: TS_W];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lat_sum_q <= '0;
            lat_max_q <= '0;
        end else if (clr_stats) begin
            lat_sum_q <= '0;
            lat_max_q <= '0;
        end else if (i_valid) begin
            lat_sum_q <= lat_sum_q + 48'(rx_lat);
            if (rx_lat > lat_max_q) begin
                lat_max_q <= rx_lat;
            end
        end
    end

    assign lat_sum   = lat_sum_q;
    assign lat_max   = lat_max_q;
    assign rx_unused = ^{i_data[T-1:PL+TS_LSB+TS_W], i_data[PL+TS_LSB-1:PL]};
`else
    logic rx_unused;

    assign lat_sum   = '0;
    assign lat_max   = '0;
    assign rx_unused = ^{i_data[T-1:PL], cyc_q};
`endif

endmodule

// File: tb/tb_noc_traffic_pe.sv
// Self-checking bench for noc_traffic_pe: four configurations (hotspot,
// transpose, bit-complement self-avoid, random) plus the receive checker.
module tb_noc_traffic_pe;

    localparam int unsigned DW = 64;
`ifdef TRAFFIC_LATENCY_STATS_EN
    localparam bit LAT_EN = 1'b1;
`else
    localparam bit LAT_EN = 1'b0;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference cycle count: zero in reset, +1 per clock.
    logic [31:0] cyc_m;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) cyc_m <= 32'd0;
        else       cyc_m <= cyc_m + 32'd1;
    end

    // ---------------- instance A: hotspot, 4x4, MY=(1,2) ----------------
    logic a_start = 0, a_clr = 0, a_ready = 0, a_ivalid = 0;
    logic a_valid, a_done;
    logic [DW+3:0] a_odata, a_idata = '0;
    logic [31:0] a_send, a_recv, a_lmax;
    logic [15:0] a_err;
    logic [47:0] a_lsum;

    noc_traffic_pe #(.X(4), .Y(4), .data_width(DW), .MY_X(1), .MY_Y(2),
        .NUM_PACKETS(4), .RATE(1), .PATTERN(3), .HOT_X(3), .HOT_Y(3)) u_a (
        .clk(clk), .rstn(rstn), .start(a_start), .clr_stats(a_clr),
        .o_valid(a_valid), .o_data(a_odata), .i_ready(a_ready),
        .i_valid(a_ivalid), .i_data(a_idata), .done(a_done),
        .send_count(a_send), .recv_count(a_recv), .err_count(a_err),
        .lat_sum(a_lsum), .lat_max(a_lmax));

    // ---------------- instance B: transpose, RATE=4 ----------------
    logic b_start = 0, b_ready = 0;
    logic b_valid, b_done;
    logic [DW+3:0] b_odata;
    logic [31:0] b_send, b_recv, b_lmax;
    logic [15:0] b_err;
    logic [47:0] b_lsum;

    noc_traffic_pe #(.X(4), .Y(4), .data_width(DW), .MY_X(1), .MY_Y(2),
        .NUM_PACKETS(1000), .RATE(4), .PATTERN(1)) u_b (
        .clk(clk), .rstn(rstn), .start(b_start), .clr_stats(1'b0),
        .o_valid(b_valid), .o_data(b_odata), .i_ready(b_ready),
        .i_valid(1'b0), .i_data('0), .done(b_done),
        .send_count(b_send), .recv_count(b_recv), .err_count(b_err),
        .lat_sum(b_lsum), .lat_max(b_lmax));

    // ---------------- instance C: bit-complement, 3x3, MY=(1,1) ----------------
    logic c_start = 0, c_ready = 0;
    logic c_valid, c_done;
    logic [DW+3:0] c_odata;
    logic [31:0] c_send, c_recv, c_lmax;
    logic [15:0] c_err;
    logic [47:0] c_lsum;

    noc_traffic_pe #(.X(3), .Y(3), .data_width(DW), .MY_X(1), .MY_Y(1),
        .NUM_PACKETS(3), .RATE(1), .PATTERN(2)) u_c (
        .clk(clk), .rstn(rstn), .start(c_start), .clr_stats(1'b0),
        .o_valid(c_valid), .o_data(c_odata), .i_ready(c_ready),
        .i_valid(1'b0), .i_data('0), .done(c_done),
        .send_count(c_send), .recv_count(c_recv), .err_count(c_err),
        .lat_sum(c_lsum), .lat_max(c_lmax));

    // ---------------- instance D: random, 10x10, MY=(3,7), SEED=0 ----------------
    logic d_start = 0, d_ready = 0;
    logic d_valid, d_done;
    logic [DW+7:0] d_odata;
    logic [31:0] d_send, d_recv, d_lmax;
    logic [15:0] d_err;
    logic [47:0] d_lsum;

    noc_traffic_pe #(.X(10), .Y(10), .data_width(DW), .MY_X(3), .MY_Y(7),
        .NUM_PACKETS(1000), .RATE(1), .PATTERN(0), .SEED(16'h0000)) u_d (
        .clk(clk), .rstn(rstn), .start(d_start), .clr_stats(1'b0),
        .o_valid(d_valid), .o_data(d_odata), .i_ready(d_ready),
        .i_valid(1'b0), .i_data('0), .done(d_done),
        .send_count(d_send), .recv_count(d_recv), .err_count(d_err),
        .lat_sum(d_lsum), .lat_max(d_lmax));

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected flit for a 2-bit x / 2-bit y mesh.
    function automatic logic [DW+3:0] flit4(input int unsigned dx, input int unsigned dy,
                                             input int unsigned seq, input logic [31:0] ts,
                                             input int unsigned sx, input int unsigned sy);
        logic [DW+3:0] f;
        f = '0;
        f[1:0]     = dx[1:0];
        f[3:2]     = dy[1:0];
        f[4 +: 16] = seq[15:0];
        f[20 +: 32] = LAT_EN ? ts : 32'd0;
        f[52 +: 8] = sx[7:0];
        f[60 +: 8] = sy[7:0];
        return f;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {fb, s[15:1]};
    endfunction

    // Receive statistics reference for instance A.
    logic [31:0] m_recv = 0, m_max = 0;
    logic [15:0] m_err = 0;
    logic [47:0] m_sum = 0;

    task automatic rx_step(input bit v, input bit clr, input int unsigned dx,
                           input int unsigned dy, input logic [31:0] lat);
        logic [15:0] junk;
        junk     = 16'($urandom);
        a_ivalid = v;
        a_clr    = clr;
        a_idata  = '0;
        a_idata[1:0]    = dx[1:0];
        a_idata[3:2]    = dy[1:0];
        a_idata[4 +: 16] = junk;
        a_idata[20 +: 32] = cyc_m - lat;
        if (clr) begin
            m_recv = 0; m_err = 0; m_sum = 0; m_max = 0;
        end else if (v) begin
            m_recv = m_recv + 1;
            if (!(dx == 1 && dy == 2) && m_err != 16'hFFFF) m_err = m_err + 1;
            m_sum = m_sum + 48'(lat);
            if (lat > m_max) m_max = lat;
        end
        @(negedge clk);
        a_ivalid = 1'b0;
        a_clr    = 1'b0;
        check("rx_recv", a_recv, m_recv);
        check("rx_err", a_err, m_err);
        check("rx_lat_sum", a_lsum, LAT_EN ? m_sum : 48'd0);
        check("rx_lat_max", a_lmax, LAT_EN ? m_max : 32'd0);
    endtask

    initial begin
        int unsigned nflit, acc, last_k, cycles, ex, ey, dx, dy;
        bit pend, in_flight;
        logic [31:0] ts;
        logic [15:0] lfsr;

        // ---- reset ----
        repeat (3) @(negedge clk);
        check("rst_valid", a_valid, 0);
        check("rst_data", a_odata, 0);
        check("rst_done", a_done, 0);
        check("rst_send", a_send, 0);
        check("rst_recv", a_recv, 0);
        check("rst_err", a_err, 0);
        check("rst_lsum", a_lsum, 0);
        check("rst_lmax", a_lmax, 0);
        rstn = 1'b1;

        // ---- hotspot injection ----
        @(negedge clk);
        a_start = 1; a_ready = 1;
        nflit = 0; acc = 0; pend = 0; last_k = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (pend) begin acc++; pend = 0; end
            check("hs_done", a_done, acc == 4);
            check("hs_send", a_send, acc);
            if (a_valid) begin
                check("hs_flit", a_odata, flit4(3, 3, nflit, cyc_m - 1, 1, 2));
                if (nflit == 0) check("hs_start_lat", k, 1);
                else            check("hs_spacing", k - last_k, 2);
                last_k = k; nflit++; pend = 1;
            end
        end
        check("hs_count", nflit, 4);
        a_start = 0;
        repeat (3) @(negedge clk);
        check("hs_done_hold", a_done, 1);
        a_start = 1;
        @(negedge clk);
        check("hs_done_clr", a_done, 0);
        check("hs_send_clr", a_send, 0);
        a_start = 0;
        repeat (4) @(negedge clk);
        check("hs_drop_send", a_send, 1);
        check("hs_drop_valid", a_valid, 0);
        a_ready = 0;

        // ---- receive checking ----
        rx_step(1, 0, 1, 2, 32'd10);
        rx_step(1, 0, 1, 2, 32'd20);
        rx_step(1, 0, 0, 2, 32'd5);
        check("rx3_recv", a_recv, 3);
        check("rx3_err", a_err, 1);
        check("rx3_sum", a_lsum, LAT_EN ? 48'd35 : 48'd0);
        check("rx3_max", a_lmax, LAT_EN ? 32'd20 : 32'd0);
        rx_step(0, 1, 0, 0, 32'd0);
        rx_step(1, 1, 0, 0, 32'd7);   // clear wins over a simultaneous arrival
        for (int i = 0; i < 60; i++) begin
            bit good;
            good = ($urandom_range(0, 1) == 1);
            rx_step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                    good ? 1 : $urandom_range(0, 3), good ? 2 : $urandom_range(0, 3),
                    ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 500));
        end

        // ---- transpose with backpressure, RATE=4, start drop ----
        b_start = 1;
        cycles = 0;
        do begin @(negedge clk); cycles++; end while (!b_valid && cycles < 20);
        check("tp_start_lat", cycles, 2);
        ts = cyc_m - 1;
        for (int i = 0; i < 5; i++) begin
            check("tp_hold_data", b_odata, flit4(2, 1, 0, ts, 1, 2));
            check("tp_hold_valid", b_valid, 1);
            check("tp_hold_send", b_send, 0);
            @(negedge clk);
        end
        b_ready = 1;
        @(negedge clk);
        b_ready = 0;
        check("tp_acc_send", b_send, 1);
        check("tp_acc_valid", b_valid, 0);
        cycles = 0;
        do begin @(negedge clk); cycles++; end while (!b_valid && cycles < 20);
        check("tp_rate_gap", cycles, 4);
        ts = cyc_m - 1;
        check("tp_flit1", b_odata, flit4(2, 1, 1, ts, 1, 2));
        b_start = 0;
        repeat (2) begin
            @(negedge clk);
            check("sd_hold_valid", b_valid, 1);
            check("sd_hold_data", b_odata, flit4(2, 1, 1, ts, 1, 2));
        end
        b_ready = 1;
        @(negedge clk);
        b_ready = 0;
        check("sd_acc_send", b_send, 2);
        repeat (6) begin
            @(negedge clk);
            check("sd_idle_valid", b_valid, 0);
            check("sd_idle_send", b_send, 2);
        end
        b_start = 1;
        @(negedge clk);
        check("sd_restart_send", b_send, 0);
        check("sd_restart_valid", b_valid, 0);
        @(negedge clk);
        check("sd_restart_flit", b_odata, flit4(2, 1, 0, cyc_m - 1, 1, 2));
        check("sd_restart_v", b_valid, 1);

        // ---- self-avoidance: bit-complement of centre of 3x3 ----
        c_start = 1; c_ready = 1;
        nflit = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (c_valid) begin
                check("sa_dest", c_odata[3:0], {2'd1, 2'd2});
                check("sa_seq", c_odata[4 +: 16], nflit);
                nflit++;
            end
        end
        check("sa_count", nflit, 3);
        check("sa_done", c_done, 1);

        // ---- random pattern, SEED=0 behaves as 16'hACE1 ----
        lfsr = 16'hACE1;
        in_flight = 0; nflit = 0;
        d_start = 1;
        for (int k = 0; k < 8000 && !d_done; k++) begin
            @(negedge clk);
            if (d_valid && !in_flight) begin
                ex = 32'(lfsr[7:0]) % 10;
                ey = 32'(lfsr[15:8]) % 10;
                if (ex == 3 && ey == 7) ex = 4;
                dx = 32'(d_odata[3:0]);
                dy = 32'(d_odata[7:4]);
                check("rnd_dest", {dy[7:0], dx[7:0]}, {ey[7:0], ex[7:0]});
                check("rnd_seq", d_odata[8 +: 16], nflit[15:0]);
                check("rnd_notself", (dx == 3 && dy == 7), 0);
                lfsr = lfsr_next(lfsr);
                nflit++;
                in_flight = 1;
            end
            d_ready = ($urandom_range(0, 3) != 0);
            if (d_valid && d_ready) in_flight = 0;
        end
        @(negedge clk);
        check("rnd_done", d_done, 1);
        check("rnd_send", d_send, 1000);
        check("rnd_count", nflit, 1000);

        // ---- asynchronous reset mid-run (B is holding a flit) ----
        @(negedge clk);
        check("ar_pre_valid", b_valid, 1);
        #2 rstn = 1'b0;
        #1;
        check("ar_valid", b_valid, 0);
        check("ar_send", b_send, 0);
        check("ar_recv", a_recv, 0);
        check("ar_done", d_done, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
